// File: rtl/bin_xs3_seq.sv
// Sequential binary-to-BCD/excess-3 converter (shift-add-3, one bit per clock).
// Optional macro BIN_XS3_LZ_BLANK_EN blanks XS3 digits above the leading nonzero BCD digit.
module bin_xs3_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Handshake: start is accepted only in IDLE or DONE; busy covers the shift
    // cycles and done is a single-cycle pulse coinciding with updated results.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   xs3_q, xs3_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted_work;
    logic               shift_out;
    logic [BCD_W-1:0]   xs3_next;
    logic               seen_nz;
    logic [3:0]         digit;

    // Add-3 correction, then the {BCD, binary} shift; the bit leaving the top digit is lost.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        shifted_work = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        shift_out    = adj[BCD_W-1];
    end

    // Excess-3 encoding of the value the final shift will produce.
    always_comb begin
        xs3_next = '0;
        seen_nz  = 1'b0;
        digit    = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = shifted_work[4*i +: 4];
            if (digit != 4'd0) begin
                seen_nz = 1'b1;
            end
            xs3_next[4*i +: 4] = digit + 4'd3;
`ifdef BIN_XS3_LZ_BLANK_EN
            if (!seen_nz && (i != 0)) begin
                xs3_next[4*i +: 4] = 4'b0000;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        xs3_d     = xs3_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bin_d     = bin_in;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                work_d    = shifted_work;
                bin_d     = bin_q << 1;
                ovf_acc_d = ovf_acc_q | shift_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted_work;
                    xs3_d   = xs3_next;
                    ovf_d   = ovf_acc_q | shift_out;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            xs3_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            xs3_q     <= xs3_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign xs3_out  = xs3_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_xs3_seq.sv
// Directed bench for bin_xs3_seq: four instances cover (8,3), (8,2), (16,5) and (1,1).
module tb_bin_xs3_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_start, a_busy, a_done, a_ovf;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd, a_xs3;
    logic        b_start, b_busy, b_done, b_ovf;
    logic [7:0]  b_bin;
    logic [7:0]  b_bcd, b_xs3;
    logic        c_start, c_busy, c_done, c_ovf;
    logic [15:0] c_bin;
    logic [19:0] c_bcd, c_xs3;
    logic        d_start, d_busy, d_done, d_ovf;
    logic [0:0]  d_bin;
    logic [3:0]  d_bcd, d_xs3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];

`ifdef BIN_XS3_LZ_BLANK_EN
    localparam logic [11:0] X0  = 12'h003;
    localparam logic [11:0] X7  = 12'h00A;
    localparam logic [11:0] X37 = 12'h06A;
    localparam logic [11:0] X42 = 12'h075;
    localparam logic [7:0]  XB0 = 8'h03;
`else
    localparam logic [11:0] X0  = 12'h333;
    localparam logic [11:0] X7  = 12'h33A;
    localparam logic [11:0] X37 = 12'h36A;
    localparam logic [11:0] X42 = 12'h375;
    localparam logic [7:0]  XB0 = 8'h33;
`endif

    bin_xs3_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .bin_in(a_bin), .busy(a_busy),
        .done(a_done), .bcd_out(a_bcd), .xs3_out(a_xs3), .overflow(a_ovf));
    bin_xs3_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .bin_in(b_bin), .busy(b_busy),
        .done(b_done), .bcd_out(b_bcd), .xs3_out(b_xs3), .overflow(b_ovf));
    bin_xs3_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .bin_in(c_bin), .busy(c_busy),
        .done(c_done), .bcd_out(c_bcd), .xs3_out(c_xs3), .overflow(c_ovf));
    bin_xs3_seq #(.BIN_W(1), .DIGITS(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .bin_in(d_bin), .busy(d_busy),
        .done(d_done), .bcd_out(d_bcd), .xs3_out(d_xs3), .overflow(d_ovf));

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int which, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 64) begin
            tick();
            lat++;
            case (which)
                0:       seen = a_done;
                1:       seen = b_done;
                2:       seen = c_done;
                default: seen = d_done;
            endcase
        end
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({a_busy, a_done, a_ovf, a_bcd, a_xs3} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_a: got busy=%b done=%b ovf=%b bcd=%h xs3=%h, want all 0",
                     a_busy, a_done, a_ovf, a_bcd, a_xs3);
        end
        n_checks++;
        if ({c_busy, c_done, c_bcd, c_xs3} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_c: got bcd=%h xs3=%h, want 0", c_bcd, c_xs3);
        end
    endtask

    task automatic test_latency();
        logic ok;
        a_bin = 8'd255; a_start = 1'b1;
        tick();
        a_start = 1'b0; a_bin = 8'd0;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!(a_busy === 1'b1 && a_done === 1'b0)) ok = 1'b0;
            if (k < 7) tick();
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_window: busy/done wrong during E0..E7, want busy=1 done=0");
        end
        tick();
        n_checks++;
        if ({a_done, a_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL done_latency: got done=%b busy=%b after E8, want 1/0", a_done, a_busy);
        end
        n_checks++;
        if ({a_bcd, a_xs3, a_ovf} !== {12'h255, 12'h588, 1'b0}) begin
            n_fail++;
            $display("FAIL conv_255: got bcd=%h xs3=%h ovf=%b, want 255/588/0", a_bcd, a_xs3, a_ovf);
        end
        tick();
        n_checks++;
        if ({a_done, a_bcd} !== {1'b0, 12'h255}) begin
            n_fail++;
            $display("FAIL done_pulse_hold: got done=%b bcd=%h, want 0/255", a_done, a_bcd);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  vin[4];
        logic [11:0] eb[4];
        logic [11:0] ex[4];
        logic [11:0] exp_bcd;
        int lat;
        vin = '{8'd0, 8'd7, 8'd37, 8'd128};
        eb  = '{12'h000, 12'h007, 12'h037, 12'h128};
        ex  = '{X0, X7, X37, 12'h45B};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(eb[i]);
            a_bin = vin[i]; a_start = 1'b1;
            tick();
            a_start = 1'b0;
            wait_done(0, lat);
            exp_bcd = exp_q.pop_front();
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL basic_lat[%0d]: got %0d edges, want 8", i, lat);
            end
            n_checks++;
            if ({a_bcd, a_xs3, a_ovf} !== {exp_bcd, ex[i], 1'b0}) begin
                n_fail++;
                $display("FAIL basic_conv[%0d]: got bcd=%h xs3=%h ovf=%b, want %h/%h/0",
                         i, a_bcd, a_xs3, a_ovf, exp_bcd, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [7:0] vin[3];
        logic [7:0] eb[3];
        logic [7:0] ex[3];
        logic       eo[3];
        vin = '{8'd200, 8'd99, 8'd255};
        eb  = '{8'h00, 8'h99, 8'h55};
        ex  = '{XB0, 8'hCC, 8'h88};
        eo  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            b_bin = vin[i]; b_start = 1'b1;
            tick();
            b_start = 1'b0;
            wait_done(1, lat);
            n_checks++;
            if ({b_bcd, b_xs3, b_ovf} !== {eb[i], ex[i], eo[i]} || lat !== 8) begin
                n_fail++;
                $display("FAIL ovf_conv[%0d]: got bcd=%h xs3=%h ovf=%b lat=%0d, want %h/%h/%b/8",
                         i, b_bcd, b_xs3, b_ovf, lat, eb[i], ex[i], eo[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a_bin = 8'd37; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        a_bin = 8'd255; a_start = 1'b1;
        tick();
        a_start = 1'b0; a_bin = 8'd3;
        wait_done(0, lat);
        n_checks++;
        if ({a_bcd, a_xs3} !== {12'h037, X37} || lat !== 5) begin
            n_fail++;
            $display("FAIL start_while_busy: got bcd=%h xs3=%h lat=%0d, want 037/%h/5",
                     a_bcd, a_xs3, lat, X37);
        end
        a_bin = 8'd128; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_checks++;
        if ({a_busy, a_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL start_in_done: got busy=%b done=%b, want 1/0", a_busy, a_done);
        end
        wait_done(0, lat);
        n_checks++;
        if ({a_bcd, a_xs3} !== {12'h128, 12'h45B} || lat !== 8) begin
            n_fail++;
            $display("FAIL back_to_back: got bcd=%h xs3=%h lat=%0d, want 128/45B/8", a_bcd, a_xs3, lat);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic seen;
        int lat;
        a_bin = 8'd99; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({a_busy, a_done, a_ovf, a_bcd, a_xs3} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_reset_a: got busy=%b done=%b bcd=%h xs3=%h, want all 0",
                     a_busy, a_done, a_bcd, a_xs3);
        end
        n_checks++;
        if ({b_ovf, b_bcd, b_xs3} !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_reset_b: got ovf=%b bcd=%h xs3=%h, want 0", b_ovf, b_bcd, b_xs3);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (a_done === 1'b1 || a_busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity=%b after reset, want 0", seen);
        end
        a_bin = 8'd42; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_done(0, lat);
        n_checks++;
        if ({a_bcd, a_xs3} !== {12'h042, X42} || lat !== 8) begin
            n_fail++;
            $display("FAIL after_reset_42: got bcd=%h xs3=%h lat=%0d, want 042/%h/8", a_bcd, a_xs3, lat, X42);
        end
        tick();
    endtask

    task automatic test_wide();
        int lat;
        c_bin = 16'd65535; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        wait_done(2, lat);
        n_checks++;
        if ({c_bcd, c_xs3, c_ovf} !== {20'h65535, 20'h98868, 1'b0} || lat !== 16) begin
            n_fail++;
            $display("FAIL wide_65535: got bcd=%h xs3=%h ovf=%b lat=%0d, want 65535/98868/0/16",
                     c_bcd, c_xs3, c_ovf, lat);
        end
        tick();
    endtask

    task automatic test_one_bit();
        int lat;
        d_bin = 1'b1; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        wait_done(3, lat);
        n_checks++;
        if ({d_bcd, d_xs3, d_ovf} !== {4'h1, 4'h4, 1'b0} || lat !== 1) begin
            n_fail++;
            $display("FAIL one_bit_1: got bcd=%h xs3=%h ovf=%b lat=%0d, want 1/4/0/1", d_bcd, d_xs3, d_ovf, lat);
        end
        d_bin = 1'b0; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        wait_done(3, lat);
        n_checks++;
        if ({d_bcd, d_xs3} !== {4'h0, 4'h3} || lat !== 1) begin
            n_fail++;
            $display("FAIL one_bit_0: got bcd=%h xs3=%h lat=%0d, want 0/3/1", d_bcd, d_xs3, lat);
        end
        tick();
    endtask

    initial begin
        a_start = 1'b0; a_bin = '0;
        b_start = 1'b0; b_bin = '0;
        c_start = 1'b0; c_bin = '0;
        d_start = 1'b0; d_bin = '0;
        test_reset();
        test_latency();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        test_one_bit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
